// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM encodings and defaults for the serial arithmetic stages
package serial_adder_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first through one full_adder
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);
    localparam int CW = cnt_width(WIDTH);
    state_t           state;
    logic [WIDTH-1:0] ra, rb, rs, next_s;
    logic             rc, fa_sum, fa_carry;
    logic [CW-1:0]    cnt;
    full_adder u_fa (
        .a    (ra[0]),
        .b    (rb[0]),
        .cin  (rc),
        .sum  (fa_sum),
        .carry(fa_carry)
    );
    // new bit enters at the MSB so the LSB-first stream lands in place after WIDTH shifts
    assign next_s = (rs >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            rc    <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    ra  <= ra >> 1;
                    rb  <= rb >> 1;
                    rs  <= next_s;
                    rc  <= fa_carry;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= next_s;
                        carry <= fa_carry;
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state <= RUN;
                        ra    <= a;
                        rb    <= b;
                        rc    <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        ready <= 1'b0;
                    end else begin
                        state <= IDLE;
                        ready <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and random checks of serial_adder at WIDTH 8, 13 and 1
module tb_serial_adder;
    logic        clk, rst;
    logic [2:0]  st;
    logic [31:0] a_drv, b_drv;
    logic        cin_drv;
    logic [7:0]  s8;
    logic [12:0] s13;
    logic [0:0]  s1;
    logic [2:0]  rdy, bsy, dn, cy;
    int          sel;
    logic [31:0] o_sum;
    logic        o_carry, o_done, o_busy, o_ready;
    int          tests, fails;
    longint      prev_sum [3];
    longint      prev_carry [3];

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st[0]), .a(a_drv[7:0]), .b(b_drv[7:0]), .cin(cin_drv),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]), .sum(s8), .carry(cy[0])
    );
    serial_adder #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .start(st[1]), .a(a_drv[12:0]), .b(b_drv[12:0]), .cin(cin_drv),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]), .sum(s13), .carry(cy[1])
    );
    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(st[2]), .a(a_drv[0:0]), .b(b_drv[0:0]), .cin(cin_drv),
        .ready(rdy[2]), .busy(bsy[2]), .done(dn[2]), .sum(s1), .carry(cy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        o_sum   = (sel == 0) ? 32'(s8) : (sel == 1) ? 32'(s13) : 32'(s1);
        o_carry = cy[sel];
        o_done  = dn[sel];
        o_busy  = bsy[sel];
        o_ready = rdy[sel];
    end

    function automatic int wid(input int s);
        return (s == 0) ? 8 : (s == 1) ? 13 : 1;
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s (dut width %0d): observed %0h expected %0h", tag, wid(sel), obs, exp);
        end
    endtask

    // reference: {carry, sum} = a + b + cin, with timing checked cycle by cycle
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                          input int gap, input bit hold);
        int     w    = wid(sel);
        longint mask = (64'd1 << w) - 1;
        longint e    = (av & mask) + (bv & mask) + longint'(cv);
        chk("ready_before_start", o_ready, 1);
        a_drv = av;
        b_drv = bv;
        cin_drv = cv;
        st[sel] = 1'b1;
        for (int i = 1; i <= w + 1; i++) begin
            @(negedge clk);
            if (!hold) st[sel] = 1'b0;
            a_drv = $urandom;
            b_drv = $urandom;
            cin_drv = 1'($urandom);
            if (i <= w) begin
                chk("busy_run", o_busy, 1);
                chk("done_run", o_done, 0);
                chk("sum_hold", o_sum, prev_sum[sel]);
                chk("carry_hold", o_carry, prev_carry[sel]);
            end else begin
                chk("done_pulse", o_done, 1);
                chk("busy_end", o_busy, 0);
                chk("sum", o_sum, e & mask);
                chk("carry", o_carry, e >> w);
            end
        end
        prev_sum[sel] = e & mask;
        prev_carry[sel] = e >> w;
        for (int g = 0; g < gap; g++) begin
            st[sel] = 1'b0;
            @(negedge clk);
            chk("done_gap", o_done, 0);
            chk("busy_gap", o_busy, 0);
            chk("ready_gap", o_ready, 1);
            chk("sum_gap", o_sum, prev_sum[sel]);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        st = '0;
        sel = 0;
        a_drv = '0;
        b_drv = '0;
        cin_drv = 1'b0;
        for (int s = 0; s < 3; s++) begin
            prev_sum[s] = 0;
            prev_carry[s] = 0;
        end
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("rst_sum", o_sum, 0);
            chk("rst_carry", o_carry, 0);
            chk("rst_done", o_done, 0);
            chk("rst_busy", o_busy, 0);
            chk("rst_ready", o_ready, 1);
        end
        rst = 1'b0;
        sel = 0;
        #1;
        run_op(32'h5A, 32'h3C, 1'b0, 1, 1'b0);
        run_op(32'hFF, 32'h01, 1'b0, 1, 1'b0);
        run_op(32'hFF, 32'hFF, 1'b1, 1, 1'b0);
        run_op(32'h01, 32'h02, 1'b0, 0, 1'b1);
        run_op(32'h80, 32'h80, 1'b0, 0, 1'b1);
        run_op(32'h01, 32'h02, 1'b0, 0, 1'b1);
        run_op(32'h80, 32'h80, 1'b0, 2, 1'b1);
        run_op(32'hFF, 32'hFF, 1'b1, 1, 1'b0);
        // abort mid-run with a nonzero result held from the previous operation
        chk("ready_pre_abort", o_ready, 1);
        a_drv = 32'h0F;
        b_drv = 32'h01;
        cin_drv = 1'b0;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_pre_abort", o_busy, 1);
        rst = 1'b1;
        #1;
        chk("abort_sum", o_sum, 0);
        chk("abort_carry", o_carry, 0);
        chk("abort_ready", o_ready, 1);
        chk("abort_busy", o_busy, 0);
        chk("abort_done", o_done, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            prev_sum[s] = 0;
            prev_carry[s] = 0;
        end
        repeat (10) begin
            @(negedge clk);
            chk("abort_no_done", o_done, 0);
            chk("abort_idle_busy", o_busy, 0);
        end
        run_op(32'h10, 32'h20, 1'b0, 1, 1'b0);
        sel = 2;
        #1;
        for (int v = 0; v < 8; v++)
            run_op(32'(v[2]), 32'(v[1]), v[0], v % 2, 1'b0);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            repeat (1000)
                run_op($urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
            st = '0;
            repeat (16) @(negedge clk);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
